// File: rtl/nonogram_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nonogram_pkg
// Description : Shared sizes, line-FIFO word field positions and the
//               line-reader state encoding for the nonogram solver front end.
// Revision    : 1.0 - initial release
// ============================================================================
package nonogram_pkg;

    localparam int MAX_DIM      = 11;   // maximum cells per line
    localparam int WORD_W       = 16;   // line-FIFO word width
    localparam int CNT_W        = 7;    // options-per-line count width
    localparam int DIM_W        = 4;    // width of n, m and line indices

    // Header word: [15]=1, [14]=is_col, [13:10]=line index, [9:7]=reserved, [6:0]=count
    localparam int HDR_FLAG_BIT = 15;
    localparam int HDR_COL_BIT  = 14;
    localparam int HDR_IDX_MSB  = 13;
    localparam int HDR_IDX_LSB  = 10;
    localparam int HDR_RSV_MSB  = 9;
    localparam int HDR_RSV_LSB  = 7;
    localparam int HDR_CNT_MSB  = 6;
    localparam int HDR_CNT_LSB  = 0;

    // Option word: [15]=0, [14:11]=0, [10:0]=cell bitmap
    localparam int OPT_PAD_MSB  = 14;
    localparam int OPT_PAD_LSB  = 11;
    localparam int OPT_MAP_MSB  = 10;
    localparam int OPT_MAP_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_HDR   = 3'd1,
        ST_WAIT_HDR = 3'd2,
        ST_RD_OPT   = 3'd3,
        ST_WAIT_OPT = 3'd4,
        ST_PRESENT  = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

endpackage : nonogram_pkg
`default_nettype wire

// File: rtl/line_reader.sv
`default_nettype none
// ============================================================================
// Module      : line_reader
// Description : Reads the per-line option lists of a nonogram board from a
//               standard-mode line FIFO (rows first, then columns), checks
//               the word format and presents one candidate option at a time
//               to the solver over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module line_reader #(
    parameter int MAX_DIM = nonogram_pkg::MAX_DIM,
    parameter int WORD_W  = nonogram_pkg::WORD_W,
    parameter int CNT_W   = nonogram_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         n,
    input  logic [3:0]         m,
    input  logic [WORD_W-1:0]  fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic               opt_valid,
    input  logic               opt_ready,
    output logic [MAX_DIM-1:0] opt_bits,
    output logic [3:0]         opt_line,
    output logic               opt_is_col,
    output logic               opt_first,
    output logic               opt_last,
    output logic               done,
    output logic               err,
    output logic               busy
);

    import nonogram_pkg::*;

    state_e             state_q,      state_d;
    logic [3:0]         n_q,          n_d;
    logic [3:0]         m_q,          m_d;
    logic               exp_col_q,    exp_col_d;
    logic [3:0]         exp_idx_q,    exp_idx_d;
    logic [CNT_W-1:0]   opts_left_q,  opts_left_d;
    logic               first_q,      first_d;
    logic [MAX_DIM-1:0] opt_bits_q,   opt_bits_d;
    logic [3:0]         opt_line_q,   opt_line_d;
    logic               opt_is_col_q, opt_is_col_d;
    logic               opt_first_q,  opt_first_d;
    logic               opt_last_q,   opt_last_d;
    logic               done_q,       done_d;

    logic               hdr_ok;
    logic               opt_ok;
    logic [CNT_W-1:0]   hdr_cnt;

    // Reserved header bits [9:7] carry no meaning and are deliberately ignored.
    logic               unused_hdr_rsv;
    assign unused_hdr_rsv = ^fifo_dout[HDR_RSV_MSB:HDR_RSV_LSB];

    assign hdr_cnt = fifo_dout[CNT_W-1:0];

    // Word-format checks on the captured FIFO word.
    always_comb begin
        hdr_ok = fifo_dout[HDR_FLAG_BIT]
              && (fifo_dout[HDR_COL_BIT] == exp_col_q)
              && (fifo_dout[HDR_IDX_MSB:HDR_IDX_LSB] == exp_idx_q)
              && (hdr_cnt != '0);
        opt_ok = !fifo_dout[HDR_FLAG_BIT]
              && (fifo_dout[OPT_PAD_MSB:OPT_PAD_LSB] == 4'd0);
    end

    // Next-state and strobe logic; registers hold unless a state says otherwise.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        m_d          = m_q;
        exp_col_d    = exp_col_q;
        exp_idx_d    = exp_idx_q;
        opts_left_d  = opts_left_q;
        first_d      = first_q;
        opt_bits_d   = opt_bits_q;
        opt_line_d   = opt_line_q;
        opt_is_col_d = opt_is_col_q;
        opt_first_d  = opt_first_q;
        opt_last_d   = opt_last_q;
        done_d       = 1'b0;
        fifo_rd_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((n == 4'd0) || (m == 4'd0)) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d       = n;
                        m_d       = m;
                        exp_col_d = 1'b0;
                        exp_idx_d = 4'd0;
                        state_d   = ST_RD_HDR;
                    end
                end
            end
            ST_RD_HDR: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_WAIT_HDR;
                end
            end
            ST_WAIT_HDR: begin
                if (hdr_ok) begin
                    opts_left_d = hdr_cnt;
                    first_d     = 1'b1;
                    state_d     = ST_RD_OPT;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_RD_OPT: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_WAIT_OPT;
                end
            end
            ST_WAIT_OPT: begin
                if (opt_ok) begin
                    opt_bits_d   = fifo_dout[MAX_DIM-1:0];
                    opt_line_d   = exp_idx_q;
                    opt_is_col_d = exp_col_q;
                    opt_first_d  = first_q;
                    opt_last_d   = (opts_left_q == CNT_W'(1));
                    state_d      = ST_PRESENT;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_PRESENT: begin
                if (opt_ready) begin
                    opts_left_d = opts_left_q - CNT_W'(1);
                    first_d     = 1'b0;
                    if (opts_left_q > CNT_W'(1)) begin
                        state_d = ST_RD_OPT;
                    end else if (!exp_col_q) begin
                        // Last row rolls over to column 0.
                        state_d = ST_RD_HDR;
                        if (exp_idx_q == n_q - 4'd1) begin
                            exp_col_d = 1'b1;
                            exp_idx_d = 4'd0;
                        end else begin
                            exp_idx_d = exp_idx_q + 4'd1;
                        end
                    end else if (exp_idx_q == m_q - 4'd1) begin
                        // Last column finished: board complete.
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        exp_idx_d = exp_idx_q + 4'd1;
                        state_d   = ST_RD_HDR;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // State, counters and output register; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            n_q          <= 4'd0;
            m_q          <= 4'd0;
            exp_col_q    <= 1'b0;
            exp_idx_q    <= 4'd0;
            opts_left_q  <= '0;
            first_q      <= 1'b0;
            opt_bits_q   <= '0;
            opt_line_q   <= 4'd0;
            opt_is_col_q <= 1'b0;
            opt_first_q  <= 1'b0;
            opt_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            m_q          <= m_d;
            exp_col_q    <= exp_col_d;
            exp_idx_q    <= exp_idx_d;
            opts_left_q  <= opts_left_d;
            first_q      <= first_d;
            opt_bits_q   <= opt_bits_d;
            opt_line_q   <= opt_line_d;
            opt_is_col_q <= opt_is_col_d;
            opt_first_q  <= opt_first_d;
            opt_last_q   <= opt_last_d;
            done_q       <= done_d;
        end
    end

    assign opt_valid  = (state_q == ST_PRESENT);
    assign err        = (state_q == ST_ERROR);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign opt_bits   = opt_bits_q;
    assign opt_line   = opt_line_q;
    assign opt_is_col = opt_is_col_q;
    assign opt_first  = opt_first_q;
    assign opt_last   = opt_last_q;

endmodule : line_reader
`default_nettype wire
